mic1_uart_loader: RTL and testbench

- Serial boot loader sitting between the board RX pin and the MIC-1 SoC main memory write port.
- Receives a framed program image over UART and writes it word-by-word into main memory.
- Holds the CPU in reset (cpu_hold) while loading; releases it when a frame completes with a good checksum.
- Instantiated inside the icebreaker top level, upstream of mic1_soc.

---
 rtl/mic1_loader_pkg.sv | 21 ++
 rtl/mic1_uart_rx.sv | 85 ++++++++
 rtl/mic1_uart_loader.sv | 166 ++++++++++++++++
 tb/tb_mic1_uart_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_loader_pkg.sv
// Shared constants and state encodings for the MIC-1 UART boot loader.
package mic1_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef logic [2:0] ld_state_t;
   localparam ld_state_t LD_SYNC    = 3'd0;
   localparam ld_state_t LD_ADDR_HI = 3'd1;
   localparam ld_state_t LD_ADDR_LO = 3'd2;
   localparam ld_state_t LD_CNT_HI  = 3'd3;
   localparam ld_state_t LD_CNT_LO  = 3'd4;
   localparam ld_state_t LD_DATA    = 3'd5;
   localparam ld_state_t LD_CHK     = 3'd6;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_START = 2'd1;
   localparam rx_state_t RX_DATA  = 2'd2;
   localparam rx_state_t RX_STOP  = 2'd3;

endpackage

// File: rtl/mic1_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, stop-bit framing check.
module mic1_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       RX,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);
   import mic1_loader_pkg::*;

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic          rx_meta_q, rx_sync_q;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         RX_IDLE: if (!rx_sync_q) begin
            state_d = RX_START;
            cnt_d   = '0;
         end
         // A start bit that is high again at mid-bit was a glitch.
         RX_START: if (cnt_q == HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_sync_q ? RX_IDLE : RX_DATA;
         end else cnt_d = cnt_q + 1'b1;
         RX_DATA: if (cnt_q == FULL) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = RX_STOP;
            else bit_d = bit_q + 1'b1;
         end else cnt_d = cnt_q + 1'b1;
         RX_STOP: if (cnt_q == FULL) begin
            state_d = RX_IDLE;
            valid_d = rx_sync_q;
            err_d   = ~rx_sync_q;
         end else cnt_d = cnt_q + 1'b1;
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign byte_valid = valid_q;
   assign byte_data  = shift_q;
   assign frame_err  = err_q;

endmodule

// File: rtl/mic1_uart_loader.sv
// UART boot loader: parses sync/addr/count/data/checksum frames and writes words to main memory.
module mic1_uart_loader #(
   parameter int unsigned CLKS_PER_BIT   = 104,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  RX,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_error
);
   import mic1_loader_pkg::*;

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned BW    = $clog2(BYTES + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BW-1:0] LAST_BYTE    = BW'(BYTES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic       rx_valid, rx_err;
   logic [7:0] rx_data;

   mic1_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .RX        (RX),
      .byte_valid(rx_valid),
      .byte_data (rx_data),
      .frame_err (rx_err)
   );

   ld_state_t             state_q, state_d;
   logic [7:0]            hi_q, hi_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [BW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [7:0]            chk_q, chk_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  hold_q, hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      chk_d   = chk_q;
      timer_d = (state_q == LD_SYNC) ? '0 : timer_q + 1'b1;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (rx_valid) begin
         timer_d = '0;
         if (state_q != LD_SYNC && state_q != LD_CHK) chk_d = chk_q ^ rx_data;
         case (state_q)
            LD_SYNC: if (rx_data == SYNC_BYTE) begin
               state_d = LD_ADDR_HI;
               hold_d  = 1'b1;
               err_d   = 1'b0;
               chk_d   = '0;
            end
            LD_ADDR_HI: begin
               hi_d    = rx_data;
               state_d = LD_ADDR_LO;
            end
            LD_ADDR_LO: begin
               addr_d  = ADDR_WIDTH'({hi_q, rx_data});
               state_d = LD_CNT_HI;
            end
            LD_CNT_HI: begin
               hi_d    = rx_data;
               state_d = LD_CNT_LO;
            end
            LD_CNT_LO: begin
               cnt_d   = {hi_q, rx_data};
               idx_d   = '0;
               state_d = ({hi_q, rx_data} == 16'd0) ? LD_CHK : LD_DATA;
            end
            LD_DATA: begin
               word_d = DATA_WIDTH'({word_q, rx_data});
               if (idx_q == LAST_BYTE) begin
                  idx_d   = '0;
                  we_d    = 1'b1;
                  maddr_d = addr_q;
                  wdata_d = word_d;
                  addr_d  = addr_q + 1'b1;
                  cnt_d   = cnt_q - 1'b1;
                  if (cnt_q == 16'd1) state_d = LD_CHK;
               end else idx_d = idx_q + 1'b1;
            end
            LD_CHK: begin
               state_d = LD_SYNC;
               if (rx_data == chk_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else err_d = 1'b1;
            end
            default: state_d = LD_SYNC;
         endcase
      end else if (state_q != LD_SYNC && (rx_err || timer_q == TIMEOUT_LAST)) begin
         // Words already written stay in memory; the CPU simply stays held.
         err_d   = 1'b1;
         state_d = LD_SYNC;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= LD_SYNC;
         hi_q    <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         chk_q   <= '0;
         timer_q <= '0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         chk_q   <= chk_d;
         timer_q <= timer_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = maddr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_error = err_q;

endmodule

// File: tb/tb_mic1_uart_loader.sv
// Bench for mic1_uart_loader: frame-level model of expected writes and done pulses.
module tb_mic1_uart_loader;

   localparam int unsigned CPB = 4;

   typedef logic [7:0] bq_t[$];

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        RX = 1'b1;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold, load_done, load_error;

   int tests = 0;
   int fails = 0;

   logic [11:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   int          exp_done = 0;

   always #5 CLK = ~CLK;

   mic1_uart_loader #(
      .CLKS_PER_BIT  (CPB),
      .ADDR_WIDTH    (12),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .RX        (RX),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_error(load_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xor_sum(input bq_t b, input int n);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < n; i++) x ^= b[i];
      return x;
   endfunction

   // b holds the bytes after sync, CHK last; queue every write and the done pulse it implies.
   task automatic expect_frame(input bq_t b);
      int          n = b.size();
      int          words;
      logic [11:0] a;
      a     = 12'({b[0], b[1]});
      words = int'({b[2], b[3]});
      for (int w = 0; w < words; w++) begin
         exp_addr_q.push_back(a);
         exp_data_q.push_back({b[4+4*w], b[5+4*w], b[6+4*w], b[7+4*w]});
         a = a + 12'd1;
      end
      if (xor_sum(b, n - 1) == b[n-1]) exp_done++;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop = 1'b1);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = bits[i];
         repeat (CPB) @(posedge CLK);
         #1;
      end
      RX = 1'b1;
      repeat (CPB) @(posedge CLK);
      #1;
   endtask

   task automatic send_body(input bq_t b);
      foreach (b[i]) send_byte(b[i]);
   endtask

   task automatic settle_check(input string name, input logic hold, input logic err);
      repeat (8) @(posedge CLK);
      #1;
      check({name, "_writes_left"}, exp_addr_q.size(), 0);
      check({name, "_done_pending"}, exp_done, 0);
      check({name, "_cpu_hold"}, cpu_hold, hold);
      check({name, "_load_error"}, load_error, err);
   endtask

   // Compare process: every write and done pulse must be one the model predicted.
   always @(negedge CLK) begin
      if (RESET_N) begin
         if (mem_we) begin
            if (exp_addr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: addr %h data %h, expected no write",
                        mem_addr, mem_wdata);
            end else begin
               check("write_addr", mem_addr, exp_addr_q.pop_front());
               check("write_data", mem_wdata, exp_data_q.pop_front());
            end
         end
         if (load_done) begin
            check("done_expected", exp_done > 0, 1);
            if (exp_done > 0) exp_done--;
            check("hold_falls_with_done", cpu_hold, 0);
            check("no_error_with_done", load_error, 0);
         end
      end
   end

   initial begin
      bq_t f1, good1, bad1, wrap, empty, part, tmo, one;
      f1 = '{8'h00, 8'h10, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'h01, 8'h23, 8'h45, 8'h67};
      wrap = '{8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11,
               8'h22, 8'h22, 8'h22, 8'h22};
      empty = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tmo   = '{8'h00, 8'h20, 8'h00, 8'h01, 8'hAA};
      part  = '{8'h00, 8'h10, 8'h00, 8'h01, 8'hDE, 8'hAD};
      one   = '{8'h00, 8'h40, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};

      // Hand-computed checksums pin the model's XOR.
      check("model_chk_f1", xor_sum(f1, f1.size()), 8'h30);
      check("model_chk_wrap", xor_sum(wrap, wrap.size()), 8'hF2);
      good1 = f1;
      good1.push_back(8'h30);
      bad1 = f1;
      bad1.push_back(8'h24);
      wrap.push_back(8'hF2);
      one.push_back(xor_sum(one, one.size()));

      repeat (3) @(posedge CLK);
      #1;
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_load_done", load_done, 0);
      check("rst_load_error", load_error, 0);
      RESET_N = 1'b1;
      repeat (4) @(posedge CLK);
      #1;

      expect_frame(good1);
      send_byte(8'hA5);
      send_body(good1);
      settle_check("good", 1'b0, 1'b0);

      expect_frame(bad1);
      send_byte(8'hA5);
      check("reload_reasserts_hold", cpu_hold, 1);
      send_body(bad1);
      settle_check("badchk", 1'b1, 1'b1);

      expect_frame(wrap);
      send_byte(8'hA5);
      check("sync_clears_error", load_error, 0);
      send_body(wrap);
      settle_check("wrap", 1'b0, 1'b0);

      expect_frame(empty);
      send_byte(8'hA5);
      send_body(empty);
      settle_check("empty", 1'b0, 1'b0);

      send_byte(8'hA5);
      send_body(tmo);
      repeat (300) @(posedge CLK);
      #1;
      check("timeout_error", load_error, 1);
      check("timeout_hold", cpu_hold, 1);
      check("timeout_no_write", exp_addr_q.size(), 0);
      expect_frame(good1);
      send_byte(8'hA5);
      send_body(good1);
      settle_check("after_timeout", 1'b0, 1'b0);

      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10, 1'b0);
      settle_check("frame_err", 1'b1, 1'b1);

      send_byte(8'h00);
      send_byte(8'hFF);
      expect_frame(good1);
      send_byte(8'hA5);
      send_body(good1);
      settle_check("garbage", 1'b0, 1'b0);

      send_byte(8'hA5);
      send_body(part);
      RESET_N = 1'b0;
      #2;
      check("async_rst_mem_addr", mem_addr, 0);
      check("async_rst_mem_wdata", mem_wdata, 0);
      check("async_rst_cpu_hold", cpu_hold, 1);
      check("async_rst_load_error", load_error, 0);
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      expect_frame(one);
      send_byte(8'hA5);
      send_body(one);
      settle_check("after_reset", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
